// File: rtl/rv32i_mmio_pkg.sv
// Shared definitions for the RV32I data-port MMIO timer.
// Holds the timer register offsets inside the 4 KiB MMIO window,
// the CTRL bit positions and a packed view of the CTRL register.
package rv32i_mmio_pkg;

    localparam logic [11:0] CTRL_OFS     = 12'h000;
    localparam logic [11:0] PRESCALE_OFS = 12'h004;
    localparam logic [11:0] COUNT_OFS    = 12'h008;
    localparam logic [11:0] COMPARE_OFS  = 12'h00C;
    localparam logic [11:0] STATUS_OFS   = 12'h010;

    localparam int CTRL_EN_BIT          = 0;
    localparam int CTRL_AUTO_RELOAD_BIT = 1;
    localparam int CTRL_IRQ_EN_BIT      = 2;

    // Field order matches the bit positions above (irq_en is bit 2).
    typedef struct packed {
        logic irq_en;
        logic auto_reload;
        logic en;
    } ctrl_t;

endpackage

// File: rtl/rv32i_prescaler.sv
// Prescaler for the MMIO timer.
// Ports:
//   clk        system clock
//   rst_n      asynchronous active-low reset
//   en_i       timer enable; while low the counter is held at 0
//   prescale_i terminal value; a tick fires every prescale_i+1 cycles
//   load_i     PRESCALE register write; restarts the count at 0
//   tick_o     one-cycle pulse when the internal count hits prescale_i
module rv32i_prescaler #(
    parameter int PRESCALE_W = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en_i,
    input  logic [PRESCALE_W-1:0] prescale_i,
    input  logic                  load_i,
    output logic                  tick_o
);

    localparam logic [PRESCALE_W-1:0] PCNT_ONE = PRESCALE_W'(1);

    logic [PRESCALE_W-1:0] pcnt_q;
    logic [PRESCALE_W-1:0] pcnt_d;

    // Tick compares against the current PRESCALE value, so a PRESCALE
    // write in a tick cycle still lets that tick through.
    assign tick_o = en_i && (pcnt_q == prescale_i);

    always_comb begin
        pcnt_d = pcnt_q + PCNT_ONE;
        if (load_i || !en_i || tick_o) begin
            pcnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pcnt_q <= '0;
        end else begin
            pcnt_q <= pcnt_d;
        end
    end

endmodule

// File: rtl/rv32i_mmio_timer.sv
// Data-port address decoder with a memory-mapped prescaled 32-bit timer.
// Sits between a single-cycle RV32I core and its data RAM: accesses inside
// the 4 KiB window at BASE_ADDR go to the timer registers, everything else
// goes to the RAM. Load data is returned combinationally (no stall path).
// Ports:
//   clk        system clock
//   rst_n      asynchronous active-low reset
//   addr       data address from the core
//   wdata      store data from the core
//   we         store strobe from the core
//   ram_rdata  read data from the data RAM
//   ram_we     store strobe to the data RAM (suppressed inside the window)
//   rdata      load data to the core
//   irq        level-sensitive timer interrupt (MATCH & IRQ_EN)
module rv32i_mmio_timer
    import rv32i_mmio_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR  = 32'hFFFF_0000,
    parameter int          PRESCALE_W = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic        we,
    input  logic [31:0] ram_rdata,
    output logic        ram_we,
    output logic [31:0] rdata,
    output logic        irq
);

    logic        sel;
    logic [11:0] ofs;
    logic        wr_ctrl, wr_prescale, wr_count, wr_compare, wr_status;
    logic        tick;

    ctrl_t                 ctrl_q,     ctrl_d;
    logic [PRESCALE_W-1:0] prescale_q, prescale_d;
    logic [31:0]           count_q,    count_d;
    logic [31:0]           compare_q,  compare_d;
    logic                  match_q,    match_d;

    logic [31:0] mmio_rdata;
    logic [31:0] prescale_ext;

    // ---------------- address decode ----------------
    assign sel = (addr[31:12] == BASE_ADDR[31:12]);
    assign ofs = addr[11:0];

    assign ram_we = we & ~sel;

    // Only exact word offsets decode; unaligned offsets fall through.
    assign wr_ctrl     = sel && we && (ofs == CTRL_OFS);
    assign wr_prescale = sel && we && (ofs == PRESCALE_OFS);
    assign wr_count    = sel && we && (ofs == COUNT_OFS);
    assign wr_compare  = sel && we && (ofs == COMPARE_OFS);
    assign wr_status   = sel && we && (ofs == STATUS_OFS);

    // ---------------- read path ----------------
    always_comb begin
        prescale_ext                   = '0;
        prescale_ext[PRESCALE_W-1:0]   = prescale_q;
    end

    always_comb begin
        mmio_rdata = '0;
        case (ofs)
            CTRL_OFS:     mmio_rdata = {29'd0, ctrl_q};
            PRESCALE_OFS: mmio_rdata = prescale_ext;
            COUNT_OFS:    mmio_rdata = count_q;
            COMPARE_OFS:  mmio_rdata = compare_q;
            STATUS_OFS:   mmio_rdata = {31'd0, match_q};
            default:      mmio_rdata = '0;
        endcase
    end

    assign rdata = sel ? mmio_rdata : ram_rdata;

    // ---------------- prescaler ----------------
    rv32i_prescaler #(
        .PRESCALE_W (PRESCALE_W)
    ) u_prescaler (
        .clk        (clk),
        .rst_n      (rst_n),
        .en_i       (ctrl_q.en),
        .prescale_i (prescale_q),
        .load_i     (wr_prescale),
        .tick_o     (tick)
    );

    // ---------------- register / counter next state ----------------
    always_comb begin
        ctrl_d     = ctrl_q;
        prescale_d = prescale_q;
        count_d    = count_q;
        compare_d  = compare_q;
        match_d    = match_q;

        // W1C first so that a match in the same cycle overrides it.
        if (wr_status && wdata[0]) begin
            match_d = 1'b0;
        end

        // Match check uses the pre-write COUNT; the COUNT write below wins.
        if (tick) begin
            if (count_q == compare_q) begin
                match_d = 1'b1;
                count_d = ctrl_q.auto_reload ? 32'd0 : count_q + 32'd1;
            end else begin
                count_d = count_q + 32'd1;
            end
        end

        if (wr_count) begin
            count_d = wdata;
        end
        if (wr_ctrl) begin
            ctrl_d.en          = wdata[CTRL_EN_BIT];
            ctrl_d.auto_reload = wdata[CTRL_AUTO_RELOAD_BIT];
            ctrl_d.irq_en      = wdata[CTRL_IRQ_EN_BIT];
        end
        if (wr_prescale) begin
            prescale_d = wdata[PRESCALE_W-1:0];
        end
        if (wr_compare) begin
            compare_d = wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl_q     <= '0;
            prescale_q <= '0;
            count_q    <= '0;
            compare_q  <= 32'hFFFF_FFFF;
            match_q    <= 1'b0;
        end else begin
            ctrl_q     <= ctrl_d;
            prescale_q <= prescale_d;
            count_q    <= count_d;
            compare_q  <= compare_d;
            match_q    <= match_d;
        end
    end

    assign irq = match_q & ctrl_q.irq_en;

endmodule

// File: tb/tb_rv32i_mmio_timer.sv
// Self-checking bench for rv32i_mmio_timer: directed scenarios followed by
// randomized accesses, all compared against a behavioural timer model.
module tb_rv32i_mmio_timer;

    localparam logic [31:0] BASE = 32'hFFFF_0000;

    logic        clk;
    logic        rst_n;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        we;
    logic [31:0] ram_rdata;
    logic        ram_we;
    logic [31:0] rdata;
    logic        irq;

    int n_cmp = 0;
    int n_err = 0;

    // behavioural model state
    logic [2:0]  m_ctrl;
    logic [15:0] m_pre;
    logic [31:0] m_cnt;
    logic [31:0] m_cmp;
    logic        m_match;
    int          m_pcnt;

    rv32i_mmio_timer #(
        .BASE_ADDR  (BASE),
        .PRESCALE_W (16)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .addr      (addr),
        .wdata     (wdata),
        .we        (we),
        .ram_rdata (ram_rdata),
        .ram_we    (ram_we),
        .rdata     (rdata),
        .irq       (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp++;
        assert (obs === exp_v) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
        end
    endtask

    task automatic model_reset();
        m_ctrl  = 3'd0;
        m_pre   = 16'd0;
        m_cnt   = 32'd0;
        m_cmp   = 32'hFFFF_FFFF;
        m_match = 1'b0;
        m_pcnt  = 0;
    endtask

    function automatic logic [31:0] model_read(input logic [11:0] o);
        case (o)
            12'h000: return {29'd0, m_ctrl};
            12'h004: return {16'd0, m_pre};
            12'h008: return m_cnt;
            12'h00C: return m_cmp;
            12'h010: return {31'd0, m_match};
            default: return 32'd0;
        endcase
    endfunction

    // One clock edge of the timer, from the register-map rules.
    task automatic model_step(input logic [31:0] a, input logic [31:0] d, input logic w);
        bit          wr;
        bit          tick;
        logic [11:0] o;
        logic [31:0] new_cnt;
        logic        new_match;
        wr        = (a[31:12] == BASE[31:12]) && w;
        o         = a[11:0];
        tick      = m_ctrl[0] && (m_pcnt == int'(m_pre));
        new_cnt   = m_cnt;
        new_match = m_match;
        if (wr && o == 12'h010 && d[0]) new_match = 1'b0;
        if (tick) begin
            if (m_cnt == m_cmp) begin
                new_match = 1'b1;
                new_cnt   = m_ctrl[1] ? 32'd0 : m_cnt + 32'd1;
            end else begin
                new_cnt = m_cnt + 32'd1;
            end
        end
        if (wr && o == 12'h004) m_pcnt = 0;
        else if (!m_ctrl[0] || tick) m_pcnt = 0;
        else m_pcnt = m_pcnt + 1;
        if (wr && o == 12'h008) new_cnt = d;
        m_cnt   = new_cnt;
        m_match = new_match;
        if (wr && o == 12'h000) m_ctrl = d[2:0];
        if (wr && o == 12'h004) m_pre  = d[15:0];
        if (wr && o == 12'h00C) m_cmp  = d;
    endtask

    // Called at posedge+1; leaves at the next posedge+1.
    task automatic do_cycle(input logic [31:0] a, input logic [31:0] d, input logic w,
                            input bit has_exp = 1'b0, input logic [31:0] exp_v = 32'd0,
                            input string tag = "");
        bit s;
        addr      = a;
        wdata     = d;
        we        = w;
        ram_rdata = $urandom;
        #2;
        s = (a[31:12] == BASE[31:12]);
        chk("rdata", rdata, s ? model_read(a[11:0]) : ram_rdata);
        chk("ram_we", {31'd0, ram_we}, {31'd0, w & ~s});
        chk("irq", {31'd0, irq}, {31'd0, m_match & m_ctrl[2]});
        if (has_exp) chk(tag, rdata, exp_v);
        @(posedge clk);
        model_step(a, d, w);
        #1;
    endtask

    task automatic wr(input logic [11:0] o, input logic [31:0] d);
        do_cycle(BASE + {20'd0, o}, d, 1'b1);
    endtask

    task automatic rd(input logic [11:0] o);
        do_cycle(BASE + {20'd0, o}, 32'd0, 1'b0);
    endtask

    task automatic rdx(input logic [11:0] o, input logic [31:0] e, input string tag);
        do_cycle(BASE + {20'd0, o}, 32'd0, 1'b0, 1'b1, e, tag);
    endtask

    // Reset asserted between edges; irq and registers must drop at once.
    task automatic apply_reset();
        addr  = BASE + 32'h8;
        wdata = 32'd0;
        we    = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("irq_async_rst", {31'd0, irq}, 32'd0);
        chk("count_async_rst", rdata, 32'd0);
        model_reset();
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    logic [31:0] exp_seq [8];
    logic [11:0] ofs_tab [8];

    initial begin
        rst_n     = 1'b0;
        addr      = 32'd0;
        wdata     = 32'd0;
        we        = 1'b0;
        ram_rdata = 32'd0;
        model_reset();
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // reset values and RAM pass-through
        rdx(12'h000, 32'd0, "rst_ctrl");
        rdx(12'h004, 32'd0, "rst_prescale");
        rdx(12'h008, 32'd0, "rst_count");
        rdx(12'h00C, 32'hFFFF_FFFF, "rst_compare");
        rdx(12'h010, 32'd0, "rst_status");
        chk("rst_irq", {31'd0, irq}, 32'd0);
        addr = 32'h0000_0100; we = 1'b1; ram_rdata = 32'hCAFE_1234; #1;
        chk("ram_we_pass", {31'd0, ram_we}, 32'd1);
        chk("ram_rdata_pass", rdata, 32'hCAFE_1234);
        @(posedge clk); #1;
        we = 1'b0;

        // prescale 3, compare 2, auto-reload with irq
        wr(12'h004, 32'd3);
        wr(12'h00C, 32'd2);
        wr(12'h000, 32'b111);
        repeat (4) rd(12'h008);
        rdx(12'h008, 32'd1, "ar_count1");
        repeat (3) rd(12'h008);
        rdx(12'h008, 32'd2, "ar_count2");
        repeat (3) rd(12'h008);
        chk("ar_irq", {31'd0, irq}, 32'd1);
        rdx(12'h008, 32'd0, "ar_reload");
        rdx(12'h010, 32'd1, "ar_match");

        // same setup without reload, then W1C
        apply_reset();
        wr(12'h004, 32'd3);
        wr(12'h00C, 32'd2);
        wr(12'h000, 32'b101);
        repeat (12) rd(12'h008);
        chk("nr_irq", {31'd0, irq}, 32'd1);
        rdx(12'h008, 32'd3, "nr_count3");
        repeat (3) rd(12'h008);
        rdx(12'h008, 32'd4, "nr_count4");
        wr(12'h010, 32'd1);
        chk("nr_irq_cleared", {31'd0, irq}, 32'd0);

        // wrap-around, no flag on wrap
        apply_reset();
        wr(12'h008, 32'hFFFF_FFFE);
        wr(12'h00C, 32'd5);
        wr(12'h000, 32'b001);
        exp_seq = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'd0, 32'd1, 32'd2, 32'd3, 32'd4, 32'd5};
        for (int i = 0; i < 7; i++) rdx(12'h008, exp_seq[i], "wrap_count");
        rdx(12'h010, 32'd0, "wrap_no_match");
        rdx(12'h010, 32'd1, "match_at_5");

        // write vs tick, W1C vs new match
        wr(12'h008, 32'h10);
        rdx(12'h008, 32'h10, "write_wins");
        wr(12'h010, 32'd1);
        rdx(12'h010, 32'd0, "w1c_clear");
        wr(12'h008, 32'd3);
        rdx(12'h008, 32'd3, "cnt3");
        rdx(12'h008, 32'd4, "cnt4");
        wr(12'h010, 32'd1);
        rdx(12'h010, 32'd1, "set_beats_w1c");

        // async reset with irq high, then store to an unmapped offset
        apply_reset();
        wr(12'h00C, 32'd0);
        wr(12'h000, 32'b101);
        rd(12'h008);
        chk("irq_before_rst", {31'd0, irq}, 32'd1);
        apply_reset();
        do_cycle(BASE + 32'h20, 32'hFFFF_FFFF, 1'b1);
        rdx(12'h000, 32'd0, "unmapped_ctrl");
        rdx(12'h004, 32'd0, "unmapped_prescale");
        rdx(12'h008, 32'd0, "unmapped_count");
        rdx(12'h00C, 32'hFFFF_FFFF, "unmapped_compare");
        rdx(12'h010, 32'd0, "unmapped_status");

        // randomized traffic against the model
        ofs_tab = '{12'h000, 12'h004, 12'h008, 12'h00C, 12'h010, 12'h020, 12'h002, 12'hFFC};
        for (int i = 0; i < 1500; i++) begin
            logic [31:0] r;
            logic [31:0] a;
            logic [31:0] d;
            logic [11:0] o;
            r = $urandom;
            if ($urandom_range(0, 199) == 0) begin
                apply_reset();
            end else if ($urandom_range(0, 3) == 0) begin
                a = $urandom & 32'h7FFF_FFFC;
                do_cycle(a, $urandom, r[0]);
            end else begin
                o = ofs_tab[$urandom_range(0, 7)];
                case (o)
                    12'h004: d = {r[31:16], 14'd0, r[1:0]};
                    12'h008: d = r[2] ? (32'hFFFF_FFFC + {30'd0, r[1:0]}) : 32'($urandom_range(0, 12));
                    12'h00C: d = 32'($urandom_range(0, 12));
                    default: d = r;
                endcase
                do_cycle(BASE + {20'd0, o}, d, ($urandom_range(0, 2) == 0));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/rv32i_mmio_timer.md
Name: rv32i_mmio_timer

Overview:
- Sits directly downstream of the single-cycle RV32I core, on its data-memory port.
- Decodes the core's data address and routes each access either to the data RAM or to a small set of memory-mapped timer registers.
- Returns the load data to the core in the same cycle, because a single-cycle core has no stall path.
- Provides a prescaled 32-bit timer with compare, auto-reload and an interrupt line exported at SoC level.

Parameters:
- BASE_ADDR, 32'hFFFF_0000: base of the 4 KiB MMIO window; the window is selected when addr[31:12] == BASE_ADDR[31:12].
- PRESCALE_W, 16: width of the PRESCALE register and of the internal prescale counter.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- addr  input  32  data address from the core (its ALUResult).
- wdata  input  32  store data from the core (its WriteData).
- we  input  1  store strobe from the core (its MemWrite).
- ram_rdata  input  32  read data from the data RAM.
- ram_we  output  1  store strobe forwarded to the data RAM.
- rdata  output  32  load data to the core (its ReadData).
- irq  output  1  timer interrupt, level-sensitive.

Behaviour:
- sel = (addr[31:12] == BASE_ADDR[31:12]).
- ram_we = we & ~sel, combinational. The RAM is never written for MMIO addresses.
- rdata is combinational: sel ? mmio_rdata : ram_rdata. Load latency is 0 cycles.
- Register map, offset = addr[11:0]:
  - 0x000 CTRL [2:0]: bit0 EN, bit1 AUTO_RELOAD, bit2 IRQ_EN. Upper bits read 0.
  - 0x004 PRESCALE [PRESCALE_W-1:0].
  - 0x008 COUNT [31:0], read/write.
  - 0x00C COMPARE [31:0].
  - 0x010 STATUS bit0 MATCH. Writing 1 to bit0 clears MATCH; writing 0 has no effect.
- Other offsets (including unaligned ones) read 0, and writes to them are ignored.
- All MMIO writes are full-word, because the core provides no byte strobes. A write takes effect at the rising clk edge on which sel & we is high.
- Reset values: CTRL=0, PRESCALE=0, COUNT=0, COMPARE=32'hFFFF_FFFF, MATCH=0, prescale counter=0. Consequently irq=0 and ram_we=we.
- Prescaler:
  - When EN=1, pcnt increments each cycle.
  - When pcnt == PRESCALE, tick=1 for that cycle and pcnt returns to 0.
  - PRESCALE=0 therefore gives a tick every cycle.
  - When EN=0, pcnt is held at 0 and tick=0.
- Counter on tick:
  - If COUNT == COMPARE: MATCH<=1, and COUNT<=0 if AUTO_RELOAD, else COUNT<=COUNT+1.
  - Otherwise COUNT<=COUNT+1. It wraps modulo 2^32 from FFFF_FFFF to 0 and sets no flag on the wrap.
- irq = MATCH & IRQ_EN, derived from registers only.
- Simultaneous events:
  - A software write to COUNT in the same cycle as a tick: the write wins. The match check still uses the pre-write COUNT.
  - A W1C of MATCH in the same cycle as a new match: set wins, so MATCH stays 1.
  - A write to PRESCALE resets pcnt to 0 in the same edge.
  - A write to CTRL clearing EN: it takes effect at that edge. A tick occurring in that same cycle is still applied.
- Reset asserted mid-operation: all state returns immediately and asynchronously to the reset values. irq drops without waiting for a clock edge.

Decomposition:
- Shared package rv32i_mmio_pkg holds:
  - register offset localparams (CTRL_OFS, PRESCALE_OFS, COUNT_OFS, COMPARE_OFS, STATUS_OFS);
  - CTRL bit-index constants;
  - a packed struct for CTRL.
- One sub-module, rv32i_prescaler, which takes en, prescale and a load pulse and outputs tick.
- Address decode, the register file and the counter logic stay in the top module.

Test Plan:
- Reset, then read each offset → CTRL=0, PRESCALE=0, COUNT=0, COMPARE=FFFF_FFFF, STATUS=0, irq=0. A RAM address 0x0000_0100 with we=1 → ram_we=1, and rdata == ram_rdata.
- Write PRESCALE=3, COMPARE=2, CTRL=0b111 → COUNT increments every 4 cycles. MATCH=1 and irq=1 on the tick where COUNT==2, and COUNT reads 0 afterwards (auto-reload).
- Same setup with CTRL=0b101 (no reload) → MATCH sets at COUNT==2, COUNT continues to 3, 4 and so on. Write STATUS=1 → irq falls on the next edge.
- COUNT=FFFF_FFFE, COMPARE=5, PRESCALE=0, EN=1 → COUNT goes FFFF_FFFF, then 0, then 1. MATCH stays 0 until COUNT==5.
- Write COUNT=0x10 on a tick cycle → reads 0x10. Issue a W1C on the exact cycle a new match occurs → MATCH remains 1.
- While the counter is running with irq=1, assert rst_n=0 between edges → irq=0 and all registers reset immediately. A store to BASE_ADDR+0x20 leaves every register unchanged and keeps ram_we=0.
